// File: rtl/booth_r4_mul_unit.sv
// Iterative radix-4 Booth multiplier for the RV32M/RV64M multiply family (MUL/MULH/MULHSU/MULHU).
// Retires one Booth digit per clock and uses a start/busy/valid handshake with a kill abort.
module booth_r4_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             kill,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy
);

  localparam int N_ITER = (WIDTH + 2) / 2;
  localparam int EXT_W  = WIDTH + 2;
  localparam int ACC_W  = 2 * WIDTH + 4;
  localparam int CNT_W  = $clog2(N_ITER + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITER - 1);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t                    state_q, state_d;
  logic [1:0]                op_q, op_d;
  logic signed [ACC_W-1:0]   mcand_q, mcand_d;
  logic [EXT_W:0]            mplier_q, mplier_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]          result_q, result_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;

  logic signed [EXT_W-1:0]   mcand_ext;
  logic signed [EXT_W-1:0]   mplier_ext;

  // Sign- or zero-extend an operand by two bits so the top Booth digit sees a proper sign.
  function automatic logic signed [EXT_W-1:0] ext_operand(
    input logic [WIDTH-1:0] v,
    input logic             is_signed
  );
    logic sign_bit;
    sign_bit = is_signed & v[WIDTH-1];
    return {{2{sign_bit}}, v};
  endfunction

  // Booth digit decode: selects 0, +-M or +-2M as a full-width two's complement partial product.
  function automatic logic signed [ACC_W-1:0] booth_pp(
    input logic [2:0]              dig,
    input logic signed [ACC_W-1:0] m
  );
    logic signed [ACC_W-1:0] pp;
    case (dig)
      3'b001, 3'b010: pp = m;
      3'b011:         pp = m <<< 1;
      3'b100:         pp = -(m <<< 1);
      3'b101, 3'b110: pp = -m;
      default:        pp = '0;
    endcase
    return pp;
  endfunction

  function automatic logic [WIDTH-1:0] select_half(
    input logic [1:0]              sel_op,
    input logic signed [ACC_W-1:0] acc
  );
    return (sel_op == OP_MUL) ? acc[WIDTH-1:0] : acc[2*WIDTH-1:WIDTH];
  endfunction

  assign mcand_ext  = ext_operand(rs1, op != OP_MULHU);
  assign mplier_ext = ext_operand(rs2, (op != OP_MULHSU) && (op != OP_MULHU));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;

    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          op_d     = op;
          mcand_d  = {{(ACC_W-EXT_W){mcand_ext[EXT_W-1]}}, mcand_ext};
          mplier_d = {mplier_ext, 1'b0};
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end

      // Each RUN edge consumes the low three multiplier bits; the multiplicand
      // shifts up by one radix-4 weight so the next digit lands at 4^(i+1).
      RUN: begin
        if (kill) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          acc_d    = acc_q + booth_pp(mplier_q[2:0], mcand_q);
          mcand_d  = mcand_q <<< 2;
          mplier_d = mplier_q >> 2;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (!kill) begin
          result_d = select_half(op_q, acc_q);
          valid_d  = 1'b1;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  // Guard bits above the product only absorb carries; they never reach an output.
  logic unused_acc_guard;
  assign unused_acc_guard = ^acc_q[ACC_W-1:2*WIDTH];

  assign result = result_q;
  assign valid  = valid_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_booth_r4_mul_unit.sv
// Randomised self-checking bench for booth_r4_mul_unit against a plain-arithmetic product model.
module tb_booth_r4_mul_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs1;
  logic [W-1:0] rs2;
  logic         kill;
  logic [W-1:0] result;
  logic         valid;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  booth_r4_mul_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .kill   (kill),
    .result (result),
    .valid  (valid),
    .busy   (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: exact product of the operands interpreted per op, then pick the half.
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] sa, sb, p;
    sa = (o == 2'b11) ? {34'd0, a} : {{34{a[31]}}, a};
    sb = (o[1] == 1'b1) ? {34'd0, b} : {{34{b[31]}}, b};
    p  = sa * sb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'h0000_0001;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op from IDLE and wait (bounded) for its valid pulse.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] r);
    int lat;
    int bcnt;
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!valid && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_valid"}, {31'd0, valid}, 32'd1);
    check_eq({tag, "_lat"}, lat, 32'd18);
    check_eq({tag, "_busycyc"}, bcnt, 32'd18);
    check_eq({tag, "_busy_at_valid"}, {31'd0, busy}, 32'd0);
    r = result;
  endtask

  logic [31:0] r;
  logic [31:0] prev;
  logic [1:0]  bo[3];
  logic [31:0] ba[3];
  logic [31:0] bb[3];
  int          tv[3];
  int          seen;
  int          guard;
  int          vcount;

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0; kill = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_result", result, 32'd0);
    check_eq("reset_valid", {31'd0, valid}, 32'd0);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    run_op("mul_7x-3", 2'b00, 32'd7, 32'hFFFF_FFFD, r);
    check_eq("mul_7x-3", r, 32'hFFFF_FFEB);
    @(negedge clk);
    check_eq("valid_one_cycle", {31'd0, valid}, 32'd0);
    check_eq("result_held", result, 32'hFFFF_FFEB);

    run_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, r);
    check_eq("mulh_min", r, 32'h4000_0000);
    run_op("mulhu_ones", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r);
    check_eq("mulhu_ones", r, 32'hFFFF_FFFE);
    run_op("mulh_ones", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r);
    check_eq("mulh_ones", r, 32'h0000_0000);
    run_op("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r);
    check_eq("mulhsu_m1", r, 32'hFFFF_FFFF);
    run_op("mulhsu_2", 2'b10, 32'd2, 32'h8000_0000, r);
    check_eq("mulhsu_2", r, 32'h0000_0001);

    // Back-to-back with start held high; inputs scrambled while busy must be ignored.
    for (int i = 0; i < 3; i++) begin
      bo[i] = 2'($urandom); ba[i] = pick_operand(); bb[i] = pick_operand();
    end
    @(negedge clk);
    start = 1'b1; op = bo[0]; rs1 = ba[0]; rs2 = bb[0];
    seen = 0; guard = 0;
    while (seen < 3 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (valid) begin
        check_eq("b2b_result", result, ref_mul(bo[seen], ba[seen], bb[seen]));
        tv[seen] = cycle;
        seen++;
        if (seen < 3) begin
          op = bo[seen]; rs1 = ba[seen]; rs2 = bb[seen];
        end else begin
          start = 1'b0;
        end
      end else begin
        op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
      end
    end
    check_eq("b2b_pulses", seen, 32'd3);
    if (seen == 3) begin
      check_eq("b2b_gap01", tv[1] - tv[0], 32'd19);
      check_eq("b2b_gap12", tv[2] - tv[1], 32'd19);
    end

    // Kill on the fifth RUN cycle.
    prev = result;
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs1 = 32'd5; rs2 = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check_eq("kill_busy", {31'd0, busy}, 32'd0);
    vcount = 0;
    repeat (25) begin
      if (valid) vcount++;
      @(negedge clk);
    end
    check_eq("kill_no_valid", vcount, 32'd0);
    check_eq("kill_result_kept", result, prev);

    // kill together with start in IDLE drops the request.
    start = 1'b1; kill = 1'b1; op = 2'b00; rs1 = 32'd3; rs2 = 32'd3;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check_eq("killstart_busy", {31'd0, busy}, 32'd0);
    vcount = 0;
    repeat (25) begin
      if (valid) vcount++;
      @(negedge clk);
    end
    check_eq("killstart_no_valid", vcount, 32'd0);

    // Reset in the middle of RUN.
    start = 1'b1; op = 2'b11; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_result", result, 32'd0);
    check_eq("midrst_valid", {31'd0, valid}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    run_op("post_rst", 2'b00, 32'h0000_1234, 32'h0000_5678, r);
    check_eq("post_rst", r, 32'h0626_0060);

    for (int i = 0; i < 2000; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom);
      ra = pick_operand();
      rb = pick_operand();
      run_op("rand", ro, ra, rb, r);
      check_eq("rand_result", r, ref_mul(ro, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
